md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. It holds the HI/LO registers and runs MULT/MULTU/DIV/DIVU with fixed latency. It also generates the `stall` signal that freezes the PC and the IF/ID register while a later HI/LO instruction waits in D. It is the producer of the stall condition that the PC register consumes.

---
 rtl/md_unit.sv | 107 ++++++++++
 tb/tb_md_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage: fixed-latency MULT/DIV with MTHI/MTLO,
// plus the D-stage stall that holds later HI/LO instructions while an operation runs.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        md_we,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        d_md_use,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_op;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic        r_busy;

   logic signed [63:0] w_sa, w_sb;
   logic signed [31:0] w_sdiv;
   logic [63:0]        w_res;
   logic [31:0]        w_udiv;
   logic               w_div0, w_ovf;

   assign w_sa   = {{32{r_a[31]}}, r_a};
   assign w_sb   = {{32{r_b[31]}}, r_b};
   assign w_div0 = (r_b == 32'd0);
   assign w_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
   // Substitute a harmless divisor so the dividers never see zero; the result is discarded anyway.
   assign w_sdiv = w_div0 ? 32'sd1 : $signed(r_b);
   assign w_udiv = w_div0 ? 32'd1  : r_b;

   // Result packed as {HI, LO}
   always_comb begin
      w_res = '0;
      case (r_op)
         2'd0: w_res = w_sa * w_sb;
         2'd1: w_res = {32'd0, r_a} * {32'd0, r_b};
         2'd2: begin
            if (w_ovf) w_res = {32'd0, 32'h8000_0000};
            else       w_res = {$signed(r_a) % w_sdiv, $signed(r_a) / w_sdiv};
         end
         default: w_res = {r_a % w_udiv, r_a / w_udiv};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= md_op[1:0];
                  r_a     <= rs_data;
                  r_b     <= rt_data;
                  r_cnt   <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                  r_busy  <= 1'b1;
                  r_state <= S_BUSY;
               end else if (md_we) begin
                  if (md_op == OP_MTHI) r_hi <= rs_data;
                  if (md_op == OP_MTLO) r_lo <= rs_data;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  // Divide by zero burns the full latency but leaves HI/LO alone.
                  if (!(r_op[1] && w_div0)) begin
                     r_hi <= w_res[63:32];
                     r_lo <= w_res[31:0];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = r_busy;
   assign stall = d_md_use & (start | r_busy);

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and latency from an
// arithmetic model; a negedge monitor pops and checks on each completion.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset, start, md_we, d_md_use;
   logic [2:0]  md_op;
   logic [31:0] rs_data, rt_data, hi, lo;
   logic        busy, stall;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
      .rs_data(rs_data), .rt_data(rt_data), .d_md_use(d_md_use),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ohi, olo, ehi, elo;
      int          lat;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_hi = '0, m_lo = '0;
   int          n_tests = 0, n_fail = 0;
   int          bcnt = 0;
   logic        pbusy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: hold check while busy, result and latency check when busy falls
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         bcnt  = 0;
         pbusy = 1'b0;
      end else begin
         if (busy) begin
            bcnt++;
            if (q.size() > 0) begin
               chk("hold_hi", hi, q[0].ohi);
               chk("hold_lo", lo, q[0].olo);
            end
         end else if (pbusy) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("res_hi", hi, e.ehi);
               chk("res_lo", lo, e.elo);
               chk("busy_cycles", 32'(bcnt), 32'(e.lat));
            end
            bcnt = 0;
         end
         pbusy = busy;
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmu, input logic junk);
      exp_t   e;
      longint sa, sb, ua, ub, qq, rr;
      logic [63:0] p;
      int     cyc;
      e.ohi = m_hi;
      e.olo = m_lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = 64'(ua * ub); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: if (b != 0) begin qq = sa / sb; rr = sa % sb; m_lo = qq[31:0]; m_hi = rr[31:0]; end
         default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      endcase
      e.ehi = m_hi;
      e.elo = m_lo;
      e.lat = op[1] ? 10 : 5;
      q.push_back(e);

      @(posedge clk); #1;
      start = 1'b1; md_op = op; rs_data = a; rt_data = b; d_md_use = dmu;
      @(negedge clk);
      chk("stall_c0", 32'(stall), 32'(dmu));
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'($urandom_range(0, 7)); rs_data = $urandom; rt_data = $urandom;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (!busy) break;
         chk("stall_busy", 32'(stall), 32'(dmu));
         if (junk && cyc == 2) begin
            start = 1'b1; md_we = 1'b1; md_op = 3'($urandom_range(0, 5)); rs_data = $urandom;
         end else if (cyc == 3) begin
            start = 1'b0; md_we = 1'b0;
         end
      end
      if (cyc > 40) chk("busy_timeout", 32'd1, 32'd0);
      chk("stall_done", 32'(stall), 32'd0);
      start = 1'b0; md_we = 1'b0; d_md_use = 1'b0;
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
      @(posedge clk); #1;
      md_we = 1'b1; md_op = op; rs_data = val;
      @(posedge clk); #1;
      md_we = 1'b0;
      if (op == 3'd4) m_hi = val; else m_lo = val;
      @(negedge clk);
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_we = 1'b0; d_md_use = 1'b0;
      md_op = '0; rs_data = '0; rt_data = '0;
      @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
      do_mt(3'd4, 32'h11);
      do_mt(3'd5, 32'h22);
      run_op(3'd3, 32'd100, 32'd0, 1'b1, 1'b0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      do_mt(3'd4, 32'hA5A5_0001);

      // Asynchronous reset in the middle of a divide
      @(posedge clk); #1;
      start = 1'b1; md_op = 3'd2; rs_data = 32'd77; rt_data = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      reset = 1'b0; md_we = 1'b1; md_op = 3'd5; rs_data = 32'h1234;
      @(negedge clk);
      chk("mtlo_pre", lo, 32'd0);
      @(posedge clk); #1 md_we = 1'b0;
      @(negedge clk);
      chk("mtlo_post", lo, 32'h1234);
      chk("mtlo_hi", hi, 32'd0);
      m_lo = 32'h1234;

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: b = -32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         run_op(3'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) do_mt(3'($urandom_range(4, 5)), $urandom);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
